// File: rtl/pcw_boot_sequencer_if.sv
// Download port between the boot sequencer (master) and pcw_core (slave).
// Handshake: a byte is written on a rising edge where dn_wr=1 and dn_wait=0;
// while dn_wait=1 the master holds dn_wr/dn_addr/dn_data unchanged.
interface pcw_boot_sequencer_if;
  logic        dn_go;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wait;

  modport master (output dn_go, output dn_wr, output dn_addr, output dn_data, input dn_wait);
  modport slave  (input dn_go, input dn_wr, input dn_addr, input dn_data, output dn_wait);
endinterface

// File: rtl/pcw_boot_sequencer.sv
// Copies the boot ROM into pcw_core's download port after reset, then pulses execute_enable.
// Optional PCW_BOOT_CHECKSUM_EN adds boot_sum, a mod-256 sum of accepted bytes.
module pcw_boot_sequencer #(
  parameter int unsigned BOOT_LEN  = 276,
  parameter int unsigned ROM_LAT   = 1,
  parameter logic [15:0] EXEC_ADDR = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        restart,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        host_dl,
  input  logic        host_wr,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_wait,
  pcw_boot_sequencer_if.master dn,
  output logic [15:0] execute_addr,
  output logic        execute_enable,
  output logic        busy,
`ifdef PCW_BOOT_CHECKSUM_EN
  output logic [7:0]  boot_sum,
`endif
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_NEXT  = 3'd3,
    S_EXEC  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0]  LAT_LAST = 2'(ROM_LAT);
  localparam logic [15:0] PTR_LAST = 16'(BOOT_LEN - 1);

  state_t      r_state;
  logic [15:0] r_ptr;
  logic [1:0]  r_lat_cnt;
  logic [15:0] r_rom_addr;
  logic        r_dn_go;
  logic        r_dn_wr;
  logic [15:0] r_dn_addr;
  logic [7:0]  r_dn_data;
  logic        r_exec;
  logic        r_busy;
`ifdef PCW_BOOT_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  // Host download overrides everything; the FSM sits in IDLE while host_dl is high,
  // so the host_dl falling edge naturally starts a fresh copy on the next clock.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_lat_cnt  <= '0;
      r_rom_addr <= '0;
      r_dn_go    <= 1'b0;
      r_dn_wr    <= 1'b0;
      r_dn_addr  <= '0;
      r_dn_data  <= '0;
      r_exec     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef PCW_BOOT_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else if (host_dl) begin
      r_state <= S_IDLE;
      r_dn_go <= 1'b0;
      r_dn_wr <= 1'b0;
      r_exec  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (restart || r_state == S_IDLE) begin
      r_state    <= S_FETCH;
      r_ptr      <= '0;
      r_lat_cnt  <= '0;
      r_rom_addr <= '0;
      r_dn_go    <= 1'b1;
      r_dn_wr    <= 1'b0;
      r_exec     <= 1'b0;
      r_busy     <= 1'b1;
`ifdef PCW_BOOT_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          // rom_addr changed on FETCH entry; data is valid after ROM_LAT cycles
          if (r_lat_cnt == LAT_LAST) begin
            r_dn_data <= rom_data;
            r_dn_addr <= r_ptr;
            r_dn_wr   <= 1'b1;
            r_lat_cnt <= '0;
            r_state   <= S_WRITE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (!dn.dn_wait) begin
            r_dn_wr <= 1'b0;
`ifdef PCW_BOOT_CHECKSUM_EN
            r_sum   <= r_sum + r_dn_data;
`endif
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_ptr == PTR_LAST) begin
            r_exec  <= 1'b1;
            r_dn_go <= 1'b0;
            r_state <= S_EXEC;
          end else begin
            r_ptr      <= r_ptr + 16'd1;
            r_rom_addr <= r_ptr + 16'd1;
            r_state    <= S_FETCH;
          end
        end
        S_EXEC: begin
          r_exec  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  assign dn.dn_go    = host_dl ? 1'b1      : r_dn_go;
  assign dn.dn_wr    = host_dl ? host_wr   : r_dn_wr;
  assign dn.dn_addr  = host_dl ? host_addr : r_dn_addr;
  assign dn.dn_data  = host_dl ? host_data : r_dn_data;
  assign host_wait   = host_dl & dn.dn_wait;

  assign rom_addr       = r_rom_addr;
  assign execute_addr   = EXEC_ADDR;
  assign execute_enable = r_exec;
  assign busy           = r_busy;
  assign o_dbg_state    = r_state;
`ifdef PCW_BOOT_CHECKSUM_EN
  assign boot_sum       = r_sum;
`endif

endmodule

// File: tb/tb_pcw_boot_sequencer.sv
// Directed bench for pcw_boot_sequencer: full copy timing, core stalls, restart,
// host download takeover and asynchronous reset. Define PCW_BOOT_CHECKSUM_EN to check boot_sum.
module tb_pcw_boot_sequencer;
  localparam int BOOT_LEN    = 276;
  localparam int EXEC_CYCLES = 4 * BOOT_LEN;
  localparam int WAIT_BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        restart = 1'b0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        host_dl   = 1'b0;
  logic        host_wr   = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_data = '0;
  logic        host_wait;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        busy;
  logic [2:0]  dbg_state;
`ifdef PCW_BOOT_CHECKSUM_EN
  logic [7:0]  boot_sum;
`endif

  pcw_boot_sequencer_if dn ();

  pcw_boot_sequencer #(.BOOT_LEN(BOOT_LEN), .ROM_LAT(1), .EXEC_ADDR(16'h0000)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .restart        (restart),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .host_dl        (host_dl),
    .host_wr        (host_wr),
    .host_addr      (host_addr),
    .host_data      (host_data),
    .host_wait      (host_wait),
    .dn             (dn.master),
    .execute_addr   (execute_addr),
    .execute_enable (execute_enable),
    .busy           (busy),
`ifdef PCW_BOOT_CHECKSUM_EN
    .boot_sum       (boot_sum),
`endif
    .o_dbg_state    (dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  // Boot ROM model: one-cycle latency, byte = addr[7:0]
  always @(posedge clk_sys) rom_data <= rom_addr[7:0];

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  logic [7:0]  exp_sum;
  int          exec_cnt = 0;

  task automatic arm_copy();
    logic [15:0] a;
    exp_q.delete();
    exp_sum  = '0;
    exec_cnt = 0;
    for (int i = 0; i < BOOT_LEN; i++) begin
      a = i[15:0];
      exp_q.push_back({a, a[7:0]});
      exp_sum = exp_sum + a[7:0];
    end
  endtask

  always @(negedge clk_sys) begin
    if (!reset && !host_dl && dn.dn_wr && !dn.dn_wait) begin
      if (exp_q.size() == 0)
        check("write_extra", {8'h00, dn.dn_addr, dn.dn_data}, 32'hFFFF_FFFF);
      else
        check("write_addr_data", {8'h00, dn.dn_addr, dn.dn_data}, {8'h00, exp_q.pop_front()});
    end
    if (execute_enable) exec_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_exec(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk_sys); #1;
      cycles++;
    end while (!execute_enable && cycles < WAIT_BUDGET);
  endtask

  // The first counted edge is the one that starts the copy when exp_cycles = EXEC_CYCLES + 1.
  task automatic run_copy(input int exp_cycles);
    int cyc;
    wait_exec(cyc);
    check("exec_seen", {31'b0, execute_enable}, 32'd1);
    check("exec_cycles", cyc, exp_cycles);
    check("dn_go_at_exec", {31'b0, dn.dn_go}, 32'd0);
    check("busy_at_exec", {31'b0, busy}, 32'd1);
    check("execute_addr", {16'b0, execute_addr}, 32'h0000);
`ifdef PCW_BOOT_CHECKSUM_EN
    check("boot_sum", {24'b0, boot_sum}, {24'b0, exp_sum});
`endif
    @(posedge clk_sys); #1;
    check("exec_one_cycle", {31'b0, execute_enable}, 32'd0);
    check("busy_done", {31'b0, busy}, 32'd0);
    check("state_done", {29'b0, dbg_state}, 32'd5);
    check("writes_left", exp_q.size(), 32'd0);
    check("exec_count", exec_cnt, 32'd1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    arm_copy();
    @(posedge clk_sys); #1;
    restart = 1'b0;
    check("restart_state", {29'b0, dbg_state}, 32'd1);
    check("restart_rom_addr", {16'b0, rom_addr}, 32'd0);
    check("restart_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_rom_addr(input logic [15:0] a);
    int n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (!(rom_addr == a && dbg_state == 3'd1) && n < WAIT_BUDGET);
    check("reach_rom_addr", {16'b0, rom_addr}, {16'b0, a});
  endtask

  task automatic wait_write(input logic [15:0] a);
    int n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (!(dn.dn_wr && dn.dn_addr == a) && n < WAIT_BUDGET);
    check("reach_write_addr", {16'b0, dn.dn_addr}, {16'b0, a});
  endtask

  task automatic stall_byte(input logic [15:0] a);
    wait_write(a);
    dn.dn_wait = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_sys); #1;
      check("stall_wr", {31'b0, dn.dn_wr}, 32'd1);
      check("stall_addr", {16'b0, dn.dn_addr}, {16'b0, a});
      check("stall_data", {24'b0, dn.dn_data}, {24'b0, a[7:0]});
    end
    dn.dn_wait = 1'b0;
    @(posedge clk_sys); #1;
    check("stall_release", {31'b0, dn.dn_wr}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    dn.dn_wait = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_state", {29'b0, dbg_state}, 32'd0);
    check("rst_rom_addr", {16'b0, rom_addr}, 32'd0);
    check("rst_dn_go", {31'b0, dn.dn_go}, 32'd0);
    check("rst_dn_wr", {31'b0, dn.dn_wr}, 32'd0);
    check("rst_dn_addr", {16'b0, dn.dn_addr}, 32'd0);
    check("rst_dn_data", {24'b0, dn.dn_data}, 32'd0);
    check("rst_exec", {31'b0, execute_enable}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_host_wait", {31'b0, host_wait}, 32'd0);

    // Full copy from reset release
    arm_copy();
    @(negedge clk_sys) reset = 1'b0;
    run_copy(EXEC_CYCLES + 1);

    // Core stall of 5 cycles on byte 10 lengthens the copy by 5
    pulse_restart();
    fork
      run_copy(EXEC_CYCLES + 5);
      stall_byte(16'd10);
    join

    // Restart mid-copy at byte 200, then again from DONE
    pulse_restart();
    wait_rom_addr(16'd200);
    check("no_partial_exec", exec_cnt, 32'd0);
    pulse_restart();
    run_copy(EXEC_CYCLES);
    pulse_restart();
    run_copy(EXEC_CYCLES);

    // Host download takes over during byte 100
    pulse_restart();
    wait_rom_addr(16'd100);
    host_dl   = 1'b1;
    host_wr   = 1'b1;
    host_addr = 16'h1234;
    host_data = 8'hA5;
    #1;
    check("host_dn_go", {31'b0, dn.dn_go}, 32'd1);
    check("host_dn_wr", {31'b0, dn.dn_wr}, 32'd1);
    check("host_dn_addr", {16'b0, dn.dn_addr}, 32'h1234);
    check("host_dn_data", {24'b0, dn.dn_data}, 32'hA5);
    check("host_wait_lo", {31'b0, host_wait}, 32'd0);
    dn.dn_wait = 1'b1;
    #1;
    check("host_wait_hi", {31'b0, host_wait}, 32'd1);
    dn.dn_wait = 1'b0;
    @(posedge clk_sys); #1;
    check("host_abort_busy", {31'b0, busy}, 32'd0);
    check("host_abort_state", {29'b0, dbg_state}, 32'd0);
    restart = 1'b1;
    @(posedge clk_sys); #1;
    restart = 1'b0;
    check("host_restart_ignored", {29'b0, dbg_state}, 32'd0);
    repeat (4) @(posedge clk_sys);
    #1;
    check("host_no_exec", exec_cnt, 32'd0);
    host_dl = 1'b0;
    host_wr = 1'b0;
    dn.dn_wait = 1'b1;
    #1;
    check("host_wait_idle", {31'b0, host_wait}, 32'd0);
    check("host_release_wr", {31'b0, dn.dn_wr}, 32'd0);
    dn.dn_wait = 1'b0;
    arm_copy();
    run_copy(EXEC_CYCLES + 1);

    // Asynchronous reset during WRITE of byte 50
    pulse_restart();
    wait_write(16'd50);
    reset = 1'b1;
    #1;
    check("arst_dn_wr", {31'b0, dn.dn_wr}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_dn_go", {31'b0, dn.dn_go}, 32'd0);
    check("arst_rom_addr", {16'b0, rom_addr}, 32'd0);
    check("arst_state", {29'b0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk_sys);
    arm_copy();
    @(negedge clk_sys) reset = 1'b0;
    run_copy(EXEC_CYCLES + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
